accum_tx: RTL and testbench
===========================

# accum_tx

Serial readout stage placed directly downstream of the accumulator. On each `sample` strobe it captures the accumulator's 8-bit value and its overflow flag into a small FIFO. It then shifts each captured entry out on a single-wire, UART-style frame (idle high) with a programmable bit period. This lets the accumulator's running total be observed off-chip without stalling it.

## Interface
- `DIV`, default 4: clock cycles per serial bit; legal range 2..255.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous flush; aborts the current frame.
- `sample` in 1: capture request for `DataIn`/`OvfIn`.
- `DataIn` in 8: accumulator value.
- `OvfIn` in 1: accumulator overflow flag.
- `TxOut` out 1: serial line; idles high.
- `busy` out 1: a frame is in progress.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out log2(DEPTH)+1: current FIFO occupancy.
- `dropped` out 1: sticky; a sample was lost because the FIFO was full.

## Operation
- FIFO entry: 9 bits, {OvfIn, DataIn}. Circular read/write pointers wrap modulo `DEPTH`.
- Push: `sample`=1 and `full`=0 writes the entry.
- Push while full: the entry is discarded and `dropped` is set. `dropped` is cleared only by `reset` or `clear`.
- Pop: when the FSM is in IDLE and `count` is nonzero, it reads the head entry into a 9-bit shift register and moves to START.
- Simultaneous push and pop (FIFO not full): `count` is unchanged.
- Full is evaluated before the pop in the same cycle, so a push while full is dropped even if a pop occurs that cycle.
- FSM states:
  - IDLE: `TxOut`=1.
  - START: `TxOut`=0.
  - DATA: 9 bits, LSB first (D0..D7, then OVF).
  - PARITY: only when `ACCUM_TX_PARITY_EN` is defined.
  - STOP: `TxOut`=1.
  - After STOP, return to IDLE.
- Each state is held for exactly `DIV` cycles, timed by a divider counter that reloads on every state or bit change.
- The DATA state uses a 4-bit bit index, counting 0..8.
- Parity: even parity, equal to the XOR of all 9 payload bits.
- `busy` = 1 in any state other than IDLE.
- `clear`:
  - Next edge: the FIFO is emptied, `count`=0, `dropped`=0, and the FSM goes to IDLE with `TxOut`=1.
  - `clear` takes precedence over a simultaneous `sample`; that sample is ignored and not counted as dropped.
- `reset` mid-frame: the frame is abandoned immediately, and all outputs take their reset values.

## Timing
- Reset values: `TxOut`=1, `busy`=0, `full`=0, `count`=0, `dropped`=0. The FSM is in IDLE and the divider and bit counters are 0.
- Capture latency: `sample` high at edge N means the entry is in the FIFO after N and `count` increments.
- Frame start: the pop happens at edge N+1. `TxOut` falls to 0 and `busy` rises after N+1.
- Frame length:
  - With the macro: 12 bits × `DIV` cycles (48 at `DIV`=4).
  - Without it: 11 × `DIV` cycles (44 at `DIV`=4).
- Back-to-back frames: IDLE lasts exactly one cycle between STOP and the next START when the FIFO is non-empty.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `ACCUM_TX_PARITY_EN`:
  - Defined: the PARITY state is inserted between DATA and STOP, carrying even parity over the 9 payload bits.
  - Undefined: the PARITY state and its logic are omitted; DATA goes directly to STOP.
- FIFO, handshake and all other behaviour are identical in both builds.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle -> outputs go immediately to `TxOut`=1, `busy`=0, `count`=0, `full`=0, `dropped`=0.
- Single frame (macro defined, `DIV`=4): one `sample` with `DataIn`=8'h03, `OvfIn`=0 -> per 4-cycle slot, `TxOut` = 0,1,1,0,0,0,0,0,0,0,0,1. Parity slot is 0. `busy` is high for 48 cycles.
- Parity and overflow: `DataIn`=8'h01, `OvfIn`=1 -> OVF slot = 1, parity slot = 0. With `DataIn`=8'h01, `OvfIn`=0 -> parity slot = 1.
- Overrun (`DEPTH`=4): `sample` high for 6 consecutive cycles (values 8'h10..8'h15) -> `count` reads 1,1,2,3,4; `full`=1. The 6th sample is dropped and `dropped`=1. Transmitted frames are 8'h10..8'h14 in order.
- Clear mid-frame: `clear` pulse during DATA with 2 entries queued -> next edge `TxOut`=1, `busy`=0, `count`=0, `dropped`=0. No further frames are sent.
- Build without macro: same stimulus as the single-frame test -> 11 slots: 0,1,1,0,0,0,0,0,0,0,1. `busy` is high for 44 cycles.

Source files
------------

// File: rtl/accum_tx_if.sv
// rtl/accum_tx_if.sv - sample capture and serial readout signal bundle for accum_tx
// master drives capture/flush requests; slave (accum_tx) drives line and FIFO status.
interface accum_tx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clear;
  logic          sample;
  logic [7:0]    DataIn;
  logic          OvfIn;
  logic          TxOut;
  logic          busy;
  logic          full;
  logic [CW-1:0] count;
  logic          dropped;

  modport master (
    output clear, sample, DataIn, OvfIn,
    input  TxOut, busy, full, count, dropped
  );

  modport slave (
    input  clear, sample, DataIn, OvfIn,
    output TxOut, busy, full, count, dropped
  );
endinterface

// File: rtl/accum_tx.sv
// rtl/accum_tx.sv - FIFO-buffered UART-style readout of accumulator value and overflow flag
// ACCUM_TX_PARITY_EN inserts an even-parity slot between the payload and the stop slot.
module accum_tx #(
  parameter int DIV   = 4,
  parameter int DEPTH = 4
) (
  input logic      clock,
  input logic      reset,
  accum_tx_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef ACCUM_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, dropped_q, dropped_d;
  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d, busy_q, busy_d;
`ifdef ACCUM_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          is_full, push, pop, slot_end;

  always_comb begin
    // Fullness is judged on the registered count, so a same-cycle pop never rescues a sample.
    is_full  = (count_q == CW'(DEPTH));
    push     = bus.sample && !bus.clear && !is_full;
    pop      = !bus.clear && (state_q == S_IDLE) && (count_q != '0);
    slot_end = (div_q == 8'(DIV - 1));

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
`ifdef ACCUM_TX_PARITY_EN
    par_d     = par_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
    if (bus.sample && is_full) dropped_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          div_d   = '0;
          shreg_d = mem_q[rd_ptr_q];
`ifdef ACCUM_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_DATA;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (slot_end) begin
          div_d = '0;
          if (bit_q == 4'd8) begin
            bit_d = '0;
`ifdef ACCUM_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef ACCUM_TX_PARITY_EN
      S_PARITY: begin
        if (slot_end) begin
          state_d = S_STOP;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = 1'b0;
      state_d   = S_IDLE;
      div_d     = '0;
      bit_d     = '0;
    end

    // Line level is decoded from the next state so TxOut stays a plain flop.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef ACCUM_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {bus.OvfIn, bus.DataIn};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      dropped_q <= 1'b0;
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef ACCUM_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      dropped_q <= dropped_d;
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef ACCUM_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.TxOut   = tx_q;
  assign bus.busy    = busy_q;
  assign bus.full    = full_q;
  assign bus.count   = count_q;
  assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_accum_tx.sv
// tb/tb_accum_tx.sv - directed bench for accum_tx (DIV=4, DEPTH=4)
// Expected frames follow the ACCUM_TX_PARITY_EN setting the bench is compiled with.
module tb_accum_tx;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef ACCUM_TX_PARITY_EN
  localparam int NSLOT = 12;
`else
  localparam int NSLOT = 11;
`endif

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  accum_tx_if #(.DEPTH(DEPTH)) bus ();

  accum_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},      32'(bus.TxOut),   32'd1);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_full"},    32'(bus.full),    32'd0);
    check({tag, "_count"},   32'(bus.count),   32'd0);
    check({tag, "_dropped"}, 32'(bus.dropped), 32'd0);
  endtask

  // Samples TxOut mid-slot while busy is high; bit index = slot number.
  task automatic rx_frame(input string tag, output logic [11:0] bits, output int ncyc);
    int guard;
    guard = 0;
    bits  = '1;
    ncyc  = 0;
    while (!bus.busy && guard < 400) begin
      tick();
      guard++;
    end
    check({tag, "_start"}, 32'(bus.busy), 32'd1);
    while (bus.busy && ncyc < 200) begin
      if ((ncyc % DIV) == DIV / 2 && (ncyc / DIV) < 12) bits[ncyc / DIV] = bus.TxOut;
      ncyc++;
      tick();
    end
  endtask

  task automatic send_one(input logic [7:0] d, input logic ovf);
    bus.DataIn = d;
    bus.OvfIn  = ovf;
    bus.sample = 1'b1;
    tick();
    bus.sample = 1'b0;
  endtask

  logic [11:0] bits;
  int          ncyc;
  int          busy_seen;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    bus.clear  = 1'b0;
    bus.sample = 1'b0;
    bus.DataIn = '0;
    bus.OvfIn  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // Single frame 8'h03: capture latency, frame start latency, slots and length.
    send_one(8'h03, 1'b0);
    check("lat_count", 32'(bus.count), 32'd1);
    check("lat_busy0", 32'(bus.busy),  32'd0);
    tick();
    check("start_busy",  32'(bus.busy),  32'd1);
    check("start_tx",    32'(bus.TxOut), 32'd0);
    check("start_count", 32'(bus.count), 32'd0);
    rx_frame("f03", bits, ncyc);
`ifdef ACCUM_TX_PARITY_EN
    check("f03_bits", 32'(bits), 32'h806);
    check("f03_par",  32'(bits[10]), 32'd0);
    check("f03_len",  32'(ncyc), 32'd48);
`else
    check("f03_bits", 32'(bits[10:0]), 32'h406);
    check("f03_len",  32'(ncyc), 32'd44);
`endif
    check("f03_idle_tx", 32'(bus.TxOut), 32'd1);

    // Overflow flag and parity.
    send_one(8'h01, 1'b1);
    rx_frame("f01o", bits, ncyc);
`ifdef ACCUM_TX_PARITY_EN
    check("f01o_bits", 32'(bits), 32'hA02);
    check("f01o_par",  32'(bits[10]), 32'd0);
`else
    check("f01o_bits", 32'(bits[10:0]), 32'h602);
`endif
    check("f01o_ovf", 32'(bits[9]), 32'd1);
    send_one(8'h01, 1'b0);
    rx_frame("f01", bits, ncyc);
`ifdef ACCUM_TX_PARITY_EN
    check("f01_bits", 32'(bits), 32'hC02);
    check("f01_par",  32'(bits[10]), 32'd1);
`else
    check("f01_bits", 32'(bits[10:0]), 32'h402);
`endif

    // Overrun: six consecutive samples into a 4-deep FIFO; receiver runs alongside.
    fork
      begin
        logic [2:0] exp_cnt [6];
        exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2;
        exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4; exp_cnt[5] = 3'd4;
        bus.sample = 1'b1;
        for (int i = 0; i < 6; i++) begin
          bus.DataIn = 8'h10 + 8'(i);
          bus.OvfIn  = 1'b0;
          tick();
          check($sformatf("ovr_count%0d", i), 32'(bus.count), 32'(exp_cnt[i]));
          if (i == 4) check("ovr_dropped_pre", 32'(bus.dropped), 32'd0);
        end
        bus.sample = 1'b0;
        check("ovr_full",    32'(bus.full),    32'd1);
        check("ovr_dropped", 32'(bus.dropped), 32'd1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          rx_frame($sformatf("ovr_f%0d", k), bits, ncyc);
          check($sformatf("ovr_data%0d", k), 32'(bits[8:1]), 32'h10 + 32'(k));
          check($sformatf("ovr_ovf%0d", k),  32'(bits[9]),   32'd0);
          if (k < 4) begin
            tick();
            check($sformatf("ovr_gap%0d", k), 32'(bus.busy), 32'd1);
          end
        end
      end
    join
    check("ovr_drained", 32'(bus.count), 32'd0);
    check("ovr_sticky",  32'(bus.dropped), 32'd1);

    // Clear mid-frame with two entries queued, colliding with a sample.
    bus.sample = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.DataIn = 8'hA0 + 8'(i);
      tick();
    end
    bus.sample = 1'b0;
    check("clr_queued", 32'(bus.count), 32'd2);
    for (int i = 0; i < DIV + 2; i++) tick();
    bus.clear  = 1'b1;
    bus.sample = 1'b1;
    bus.DataIn = 8'hEE;
    tick();
    bus.clear  = 1'b0;
    bus.sample = 1'b0;
    check_idle("clr");
    busy_seen = 0;
    for (int i = 0; i < 3 * NSLOT * DIV; i++) begin
      tick();
      if (bus.busy) busy_seen = 1;
    end
    check("clr_no_frames", 32'(busy_seen), 32'd0);

    // Asynchronous reset mid-frame, mid-cycle.
    send_one(8'h5A, 1'b1);
    send_one(8'h33, 1'b0);
    for (int i = 0; i < 2 * DIV; i++) tick();
    check("rst_pre_busy", 32'(bus.busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_idle("rst_async");
    #3;
    reset = 1'b0;
    tick();
    tick();
    check_idle("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
